// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and defaults for the countdown controller slice.
// Latency: n/a (types, constants and constant helper functions only).
// Backpressure: n/a.
package countdown_pkg;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } ctrl_state_t;

  localparam int TIME_W            = 6;
  localparam int HOLD_CYCLES_DEF   = 25_000_000;
  localparam int REPEAT_CYCLES_DEF = 5_000_000;
  localparam int ALARM_CYCLES_DEF  = 500_000_000;

  // Width of a counter that must reach the larger of the hold and repeat intervals.
  function automatic int hold_cnt_w(input int hold_cycles, input int repeat_cycles);
    int max_cyc;
    max_cyc = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return $clog2(max_cyc + 1);
  endfunction

  // States in which plus/minus may step the time.
  function automatic logic is_step_state(input ctrl_state_t s);
    return (s == SET) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: edge detect plus hold-to-repeat for one step button, producing one-cycle step pulses.
// Latency: first pulse one cycle after the rise; next after HOLD_CYCLES, then every REPEAT_CYCLES.
// Backpressure: none; inhibit clears the hold counter and suppresses pulses in the same cycle.
module btn_repeat
  import countdown_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  input  logic inhibit,
  output logic rise,
  output logic pulse
);

  localparam int CNT_W = hold_cnt_w(HOLD_CYCLES, REPEAT_CYCLES);

  logic             arm_q;
  logic             prev_q;
  logic             rep_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] thr;

  // A level already high when reset releases must not look like a press, hence arm_q.
  assign rise  = btn & ~prev_q & arm_q;
  assign pulse = pulse_q;
  // First interval after the initial pulse is the long hold, later ones the repeat rate.
  assign thr   = rep_q ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES);

  // Edge-detect history and post-reset arming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      arm_q  <= 1'b1;
      prev_q <= btn;
    end
  end

  // Hold/repeat counter; cnt_q==0 means not armed, so a held button without a rise stays silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else if (inhibit || !btn) begin
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else if (rise) begin
      cnt_q   <= CNT_W'(1);
      rep_q   <= 1'b0;
      pulse_q <= 1'b1;
    end else if (cnt_q == '0) begin
      pulse_q <= 1'b0;
    end else if (cnt_q >= thr) begin
      cnt_q   <= CNT_W'(1);
      rep_q   <= 1'b1;
      pulse_q <= 1'b1;
    end else begin
      pulse_q <= 1'b0;
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: SET/RUN/PAUSE/ALARM sequencer turning debounced buttons into time-block controls.
// Latency: button edge to state/tmr_* one cycle; tmr_enable drops combinationally at 00:00:00.
// Backpressure: none, buttons sampled every cycle. Optional alarm timeout: CTRL_ALARM_TIMEOUT_EN.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int ALARM_CYCLES  = ALARM_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_start,
  input  logic              btn_clear,
  input  logic              btn_plus,
  input  logic              btn_minus,
  input  logic [TIME_W-1:0] hours,
  input  logic [TIME_W-1:0] mins,
  input  logic [TIME_W-1:0] secs,
  output logic              tmr_enable,
  output logic              tmr_reset,
  output logic              tmr_plus,
  output logic              tmr_minus,
  output logic              alarm,
  output logic [1:0]        state
);

  ctrl_state_t state_q;
  ctrl_state_t state_nxt;

  logic edge_arm_q;
  logic start_prev_q;
  logic clear_prev_q;
  logic tmr_reset_q;
  logic start_rise;
  logic clear_rise;
  logic plus_rise;
  logic minus_rise;
  logic zero;
  logic step_ok;
  logic alarm_timeout;

  assign zero       = (hours == '0) && (mins == '0) && (secs == '0);
  assign start_rise = btn_start & ~start_prev_q & edge_arm_q;
  assign clear_rise = btn_clear & ~clear_prev_q & edge_arm_q;
  assign tmr_reset  = tmr_reset_q;
  assign state      = state_q;

  // Start/clear edge history; edge_arm_q ignores levels already high at reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_arm_q   <= 1'b0;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      edge_arm_q   <= 1'b1;
      start_prev_q <= btn_start;
      clear_prev_q <= btn_clear;
    end
  end

  // Clear pulse lines up with the cycle the state lands in SET.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_reset_q <= 1'b0;
    end else begin
      tmr_reset_q <= clear_rise;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SET;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: clear wins everywhere; in RUN reaching zero wins over start.
  always_comb begin
    state_nxt = state_q;
    if (clear_rise) begin
      state_nxt = SET;
    end else begin
      unique case (state_q)
        SET:   if (start_rise && !zero) state_nxt = RUN;
        RUN: begin
          if (zero)            state_nxt = ALARM;
          else if (start_rise) state_nxt = PAUSE;
        end
        PAUSE: if (start_rise) state_nxt = zero ? SET : RUN;
        ALARM: if (start_rise || plus_rise || minus_rise || alarm_timeout) state_nxt = SET;
        default: state_nxt = SET;
      endcase
    end
  end

  // Outputs; tmr_enable gates on zero directly so the time block never wraps past 00:00:00.
  always_comb begin
    tmr_enable = (state_q == RUN) && !zero;
    alarm      = (state_q == ALARM);
    step_ok    = !clear_rise && is_step_state(state_q) && is_step_state(state_nxt);
  end

  btn_repeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_plus (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_plus),
    .inhibit (!step_ok || btn_minus),
    .rise    (plus_rise),
    .pulse   (tmr_plus)
  );

  btn_repeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_minus (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_minus),
    .inhibit (!step_ok || btn_plus),
    .rise    (minus_rise),
    .pulse   (tmr_minus)
  );

`ifdef CTRL_ALARM_TIMEOUT_EN
  localparam int ALARM_W = $clog2(ALARM_CYCLES + 1);

  logic [ALARM_W-1:0] alarm_cnt_q;

  assign alarm_timeout = (state_q == ALARM) && (alarm_cnt_q == ALARM_W'(ALARM_CYCLES - 1));

  // Counts cycles spent in ALARM; clears on the same edge that leaves ALARM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_cnt_q <= '0;
    end else if ((state_q == ALARM) && (state_nxt == ALARM)) begin
      alarm_cnt_q <= alarm_cnt_q + 1'b1;
    end else begin
      alarm_cnt_q <= '0;
    end
  end
`else
  logic unused_alarm_cfg;

  // ALARM persists until acknowledged; the timeout length is only referenced here.
  assign alarm_timeout    = 1'b0;
  assign unused_alarm_cfg = ^ALARM_CYCLES;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed bench for countdown_ctrl with HOLD=4, REPEAT=2, ALARM=8.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a; honours CTRL_ALARM_TIMEOUT_EN for the alarm-exit scenario.
module tb_countdown_ctrl;

  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int ALM  = 8;

  localparam logic [1:0] S_SET   = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_start, btn_clear, btn_plus, btn_minus;
  logic [5:0] hours, mins, secs;
  logic       tmr_enable, tmr_reset, tmr_plus, tmr_minus, alarm;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .ALARM_CYCLES  (ALM)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_plus   (btn_plus),
    .btn_minus  (btn_minus),
    .hours      (hours),
    .mins       (mins),
    .secs       (secs),
    .tmr_enable (tmr_enable),
    .tmr_reset  (tmr_reset),
    .tmr_plus   (tmr_plus),
    .tmr_minus  (tmr_minus),
    .alarm      (alarm),
    .state      (state)
  );

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours = 6'(h);
    mins  = 6'(m);
    secs  = 6'(s);
  endtask

  task automatic test_reset();
    n_cmp++; if (state !== S_SET)   begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state, S_SET); end
    n_cmp++; if (tmr_enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable: got %b want 0", tmr_enable); end
    n_cmp++; if (tmr_reset !== 1'b0)  begin n_bad++; $display("FAIL reset_tmr_reset: got %b want 0", tmr_reset); end
    n_cmp++; if (tmr_plus !== 1'b0)   begin n_bad++; $display("FAIL reset_plus: got %b want 0", tmr_plus); end
    n_cmp++; if (tmr_minus !== 1'b0)  begin n_bad++; $display("FAIL reset_minus: got %b want 0", tmr_minus); end
    n_cmp++; if (alarm !== 1'b0)      begin n_bad++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    reset_n = 1'b1;
    // start and plus were already high at release: no edge may be seen
    for (int i = 0; i < 3; i++) begin
      nxt();
      n_cmp++; if (state !== S_SET)  begin n_bad++; $display("FAIL held_at_release_state: cyc %0d got %0d want %0d", i, state, S_SET); end
      n_cmp++; if (tmr_plus !== 1'b0) begin n_bad++; $display("FAIL held_at_release_plus: cyc %0d got %b want 0", i, tmr_plus); end
    end
    btn_start = 1'b0;
    btn_plus  = 1'b0;
    nxt();
  endtask

  task automatic test_hold_repeat();
    logic [12:0] exp_mask;
    exp_mask = 13'b0_0010_1010_0010;  // pulses at cycles 1, 5, 7, 9 after the rise
    set_time(0, 0, 5);
    btn_plus = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      nxt();
      n_cmp++; if (tmr_plus !== exp_mask[k]) begin n_bad++; $display("FAIL hold_repeat_plus: cyc %0d got %b want %b", k, tmr_plus, exp_mask[k]); end
      n_cmp++; if (tmr_minus !== 1'b0) begin n_bad++; $display("FAIL hold_repeat_minus: cyc %0d got %b want 0", k, tmr_minus); end
      if (k == 10) btn_plus = 1'b0;
    end
  endtask

  task automatic test_both_buttons();
    btn_minus = 1'b1;
    nxt();
    n_cmp++; if (tmr_minus !== 1'b1) begin n_bad++; $display("FAIL both_first_minus: got %b want 1", tmr_minus); end
    n_cmp++; if (tmr_plus !== 1'b0)  begin n_bad++; $display("FAIL both_first_plus: got %b want 0", tmr_plus); end
    btn_plus = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt();
      n_cmp++; if ({tmr_plus, tmr_minus} !== 2'b00) begin n_bad++; $display("FAIL both_held: cyc %0d got plus=%b minus=%b want 00", i, tmr_plus, tmr_minus); end
    end
    btn_plus  = 1'b0;
    btn_minus = 1'b0;
    nxt();
  endtask

  task automatic test_run_alarm();
    set_time(0, 0, 2);
    btn_start = 1'b1;
    #1;
    n_cmp++; if (tmr_enable !== 1'b0) begin n_bad++; $display("FAIL run_pre_enable: got %b want 0", tmr_enable); end
    nxt();
    n_cmp++; if (state !== S_RUN)     begin n_bad++; $display("FAIL run_entry_state: got %0d want %0d", state, S_RUN); end
    n_cmp++; if (tmr_enable !== 1'b1) begin n_bad++; $display("FAIL run_entry_enable: got %b want 1", tmr_enable); end
    btn_start = 1'b0;
    set_time(0, 0, 1);
    nxt();
    n_cmp++; if (tmr_enable !== 1'b1) begin n_bad++; $display("FAIL run_one_sec_enable: got %b want 1", tmr_enable); end
    set_time(0, 0, 0);
    #1;
    n_cmp++; if (tmr_enable !== 1'b0) begin n_bad++; $display("FAIL zero_same_cycle_enable: got %b want 0", tmr_enable); end
    n_cmp++; if (state !== S_RUN)     begin n_bad++; $display("FAIL zero_same_cycle_state: got %0d want %0d", state, S_RUN); end
    nxt();
    n_cmp++; if (state !== S_ALARM)   begin n_bad++; $display("FAIL alarm_state: got %0d want %0d", state, S_ALARM); end
    n_cmp++; if (alarm !== 1'b1)      begin n_bad++; $display("FAIL alarm_flag: got %b want 1", alarm); end
    n_cmp++; if (tmr_enable !== 1'b0) begin n_bad++; $display("FAIL alarm_enable: got %b want 0", tmr_enable); end
  endtask

  task automatic test_alarm_exit();
`ifdef CTRL_ALARM_TIMEOUT_EN
    for (int i = 1; i < ALM; i++) begin
      nxt();
      n_cmp++; if (state !== S_ALARM) begin n_bad++; $display("FAIL alarm_hold: cyc %0d got %0d want %0d", i, state, S_ALARM); end
    end
    nxt();
    n_cmp++; if (state !== S_SET) begin n_bad++; $display("FAIL alarm_timeout_state: got %0d want %0d", state, S_SET); end
    n_cmp++; if (alarm !== 1'b0)  begin n_bad++; $display("FAIL alarm_timeout_flag: got %b want 0", alarm); end
`else
    repeat (10) nxt();
    n_cmp++; if (state !== S_ALARM) begin n_bad++; $display("FAIL alarm_persist_state: got %0d want %0d", state, S_ALARM); end
    n_cmp++; if (alarm !== 1'b1)    begin n_bad++; $display("FAIL alarm_persist_flag: got %b want 1", alarm); end
    btn_plus = 1'b1;
    nxt();
    n_cmp++; if (state !== S_SET)    begin n_bad++; $display("FAIL alarm_ack_state: got %0d want %0d", state, S_SET); end
    n_cmp++; if (alarm !== 1'b0)     begin n_bad++; $display("FAIL alarm_ack_flag: got %b want 0", alarm); end
    n_cmp++; if (tmr_plus !== 1'b0)  begin n_bad++; $display("FAIL alarm_ack_plus: got %b want 0", tmr_plus); end
    for (int i = 0; i < 6; i++) begin
      nxt();
      n_cmp++; if (tmr_plus !== 1'b0) begin n_bad++; $display("FAIL alarm_ack_held_plus: cyc %0d got %b want 0", i, tmr_plus); end
    end
    btn_plus = 1'b0;
    nxt();
`endif
  endtask

  task automatic test_start_at_zero();
    set_time(0, 0, 0);
    btn_start = 1'b1;
    nxt();
    n_cmp++; if (state !== S_SET)     begin n_bad++; $display("FAIL zero_start_state: got %0d want %0d", state, S_SET); end
    n_cmp++; if (tmr_enable !== 1'b0) begin n_bad++; $display("FAIL zero_start_enable: got %b want 0", tmr_enable); end
    btn_start = 1'b0;
    nxt();
    n_cmp++; if (state !== S_SET)     begin n_bad++; $display("FAIL zero_start_after: got %0d want %0d", state, S_SET); end
  endtask

  task automatic test_pause();
    set_time(0, 1, 0);
    btn_start = 1'b1;
    nxt();
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL pause_run_entry: got %0d want %0d", state, S_RUN); end
    btn_start = 1'b0;
    btn_plus  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt();
      n_cmp++; if (tmr_plus !== 1'b0) begin n_bad++; $display("FAIL run_ignores_plus: cyc %0d got %b want 0", i, tmr_plus); end
    end
    btn_plus  = 1'b0;
    nxt();
    btn_start = 1'b1;
    nxt();
    n_cmp++; if (state !== S_PAUSE)   begin n_bad++; $display("FAIL pause_state: got %0d want %0d", state, S_PAUSE); end
    n_cmp++; if (tmr_enable !== 1'b0) begin n_bad++; $display("FAIL pause_enable: got %b want 0", tmr_enable); end
    btn_start = 1'b0;
    btn_minus = 1'b1;
    nxt();
    n_cmp++; if (tmr_minus !== 1'b1) begin n_bad++; $display("FAIL pause_minus_pulse: got %b want 1", tmr_minus); end
    n_cmp++; if (tmr_plus !== 1'b0)  begin n_bad++; $display("FAIL pause_minus_plus: got %b want 0", tmr_plus); end
    btn_minus = 1'b0;
    nxt();
    n_cmp++; if (tmr_minus !== 1'b0) begin n_bad++; $display("FAIL pause_minus_single: got %b want 0", tmr_minus); end
    btn_start = 1'b1;
    nxt();
    n_cmp++; if (state !== S_RUN)     begin n_bad++; $display("FAIL resume_state: got %0d want %0d", state, S_RUN); end
    n_cmp++; if (tmr_enable !== 1'b1) begin n_bad++; $display("FAIL resume_enable: got %b want 1", tmr_enable); end
    btn_start = 1'b0;
    nxt();
  endtask

  task automatic test_clear_start();
    btn_start = 1'b1;
    btn_clear = 1'b1;
    nxt();
    n_cmp++; if (state !== S_SET)    begin n_bad++; $display("FAIL clear_start_state: got %0d want %0d", state, S_SET); end
    n_cmp++; if (tmr_reset !== 1'b1) begin n_bad++; $display("FAIL clear_start_pulse: got %b want 1", tmr_reset); end
    btn_start = 1'b0;
    btn_clear = 1'b0;
    nxt();
    n_cmp++; if (tmr_reset !== 1'b0) begin n_bad++; $display("FAIL clear_pulse_width: got %b want 0", tmr_reset); end
    n_cmp++; if (state !== S_SET)    begin n_bad++; $display("FAIL clear_after_state: got %0d want %0d", state, S_SET); end
  endtask

  task automatic test_clear_cancels();
    set_time(0, 1, 0);
    btn_plus = 1'b1;
    nxt();
    n_cmp++; if (tmr_plus !== 1'b1) begin n_bad++; $display("FAIL cancel_first_pulse: got %b want 1", tmr_plus); end
    nxt();
    btn_clear = 1'b1;
    nxt();
    n_cmp++; if (tmr_reset !== 1'b1) begin n_bad++; $display("FAIL cancel_reset_pulse: got %b want 1", tmr_reset); end
    btn_clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nxt();
      n_cmp++; if (tmr_plus !== 1'b0) begin n_bad++; $display("FAIL cancel_no_repeat: cyc %0d got %b want 0", i, tmr_plus); end
    end
    btn_plus = 1'b0;
    nxt();
  endtask

  initial begin
    reset_n   = 1'b0;
    btn_start = 1'b1;
    btn_clear = 1'b0;
    btn_plus  = 1'b1;
    btn_minus = 1'b0;
    set_time(0, 0, 5);
    nxt();
    nxt();
    test_reset();
    test_hold_repeat();
    test_both_buttons();
    test_run_alarm();
    test_alarm_exit();
    test_start_at_zero();
    test_pause();
    test_clear_start();
    test_clear_cancels();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
